// File: rtl/cla_sched_pkg.sv
// Shared types and width helpers for the cla_sched adder-slice scheduler.
package cla_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int op_w(input int seg_w, input int nseg);
    return seg_w * nseg;
  endfunction

endpackage

// File: rtl/cla_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import cla_sched_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Walk offsets from far to near so the nearest hit overwrites the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      int j;
      j = (int'(ptr) + off) % NREQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cla_sched.sv
// Time-shares one SEG_W-bit CLA slice between NREQ requesters, LS segment first.
// Optional rsp_zero output is enabled by defining CLA_SCHED_ZERO_FLAG_EN.
module cla_sched
  import cla_sched_pkg::*;
#(
  parameter int  NREQ  = 4,
  parameter int  SEG_W = 16,
  parameter int  NSEG  = 2,
  localparam int OP_W  = op_w(SEG_W, NSEG),
  localparam int ID_W  = id_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_sub,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic [SEG_W-1:0]     add_a,
  output logic [SEG_W-1:0]     add_b,
  output logic                 add_cin,
  input  logic [SEG_W-1:0]     add_sum,
  input  logic                 add_g,
  input  logic                 add_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [OP_W-1:0]      rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_lt
`ifdef CLA_SCHED_ZERO_FLAG_EN
  , output logic               rsp_zero
`endif
);

  localparam int SEG_CW = (NSEG > 1) ? $clog2(NSEG) : 1;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [SEG_CW-1:0] seg;
  logic              carry_q;
  logic              sub_q;
  logic [ID_W-1:0]   id_q;
  logic [OP_W-1:0]   a_q, b_q, sum_q;

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [SEG_W-1:0]  a_seg, b_seg;
  logic              last_seg;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign a_seg    = a_q[seg*SEG_W +: SEG_W];
  assign b_seg    = b_q[seg*SEG_W +: SEG_W];
  assign last_seg = (seg == SEG_CW'(NSEG - 1));

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = rst ? '0 : gnt;
        if (gnt_any) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_seg;
        add_b   = sub_q ? ~b_seg : b_seg;
        add_cin = carry_q;
        if (last_seg) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      seg     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (gnt_any) begin
          a_q     <= req_a[gnt_idx*OP_W +: OP_W];
          b_q     <= req_b[gnt_idx*OP_W +: OP_W];
          sub_q   <= req_sub[gnt_idx];
          carry_q <= req_sub[gnt_idx];
          id_q    <= gnt_idx;
          seg     <= '0;
          rr_ptr  <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
        RUN: begin
          // Group G/P chain the carry into the next segment.
          sum_q[seg*SEG_W +: SEG_W] <= add_sum;
          carry_q <= add_g | (add_p & carry_q);
          if (!last_seg) seg <= seg + SEG_CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_SCHED_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        zero_q <= 1'b0;
    else if (state == IDLE && gnt_any) zero_q <= 1'b1;
    else if (state == RUN)          zero_q <= zero_q & (add_sum == '0);
  end
  assign rsp_zero = zero_q;
`endif

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_lt    = sub_q & ~carry_q;

endmodule

// File: tb/tb_cla_sched.sv
// Directed bench for cla_sched with a behavioural 16-bit CLA slice attached.
module tb_cla_sched;

  localparam int NREQ  = 4;
  localparam int SEG_W = 16;
  localparam int NSEG  = 2;
  localparam int OP_W  = SEG_W * NSEG;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, req_sub;
  logic [NREQ*OP_W-1:0] req_a, req_b;
  logic [SEG_W-1:0]     add_a, add_b, add_sum;
  logic                 add_cin, add_g, add_p;
  logic                 rsp_valid, rsp_ready, rsp_cout, rsp_lt;
  logic [1:0]           rsp_id;
  logic [OP_W-1:0]      rsp_sum;
`ifdef CLA_SCHED_ZERO_FLAG_EN
  logic                 rsp_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Adder slice model: G/P computed without carry-in.
  logic [SEG_W:0] raw;
  assign raw     = {1'b0, add_a} + {1'b0, add_b};
  assign add_g   = raw[SEG_W];
  assign add_p   = &(add_a ^ add_b);
  assign add_sum = add_a + add_b + {{(SEG_W-1){1'b0}}, add_cin};

  cla_sched #(.NREQ(NREQ), .SEG_W(SEG_W), .NSEG(NSEG)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_g(add_g), .add_p(add_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_lt(rsp_lt)
`ifdef CLA_SCHED_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  // Single requester; returns at the negedge after acceptance with req_valid cleared.
  task automatic issue(input int id, input logic sub, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    @(negedge clk);
    req_a[id*OP_W +: OP_W] = a;
    req_b[id*OP_W +: OP_W] = b;
    req_sub[id] = sub;
    req_valid = '0;
    req_valid[id] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = rsp_valid;
  endtask

  task automatic drain;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'hF; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_sum !== '0 || add_a !== '0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset: req_ready=%b rsp_valid=%b rsp_sum=%h add_a=%h cin=%b, want 0s", req_ready, rsp_valid, rsp_sum, add_a, add_cin);
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_add_carry;
    @(negedge clk);
    req_a[0 +: OP_W] = 32'h0000FFFF; req_b[0 +: OP_W] = 32'h00000001; req_sub[0] = 1'b0;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_grant: got %b want 0001", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0 || add_a !== 16'hFFFF || add_b !== 16'h0001 || add_cin !== 1'b0) begin
      errors++; $display("FAIL add_seg0: valid=%b a=%h b=%h cin=%b want 0 ffff 0001 0", rsp_valid, add_a, add_b, add_cin);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || add_a !== 16'h0000 || add_cin !== 1'b1) begin
      errors++; $display("FAIL add_seg1: valid=%b a=%h cin=%b want 0 0000 1", rsp_valid, add_a, add_cin);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h00010000 || rsp_cout !== 1'b0 || rsp_id !== 2'd0 || rsp_lt !== 1'b0) begin
      errors++; $display("FAIL add_rsp: valid=%b sum=%h cout=%b id=%0d lt=%b want 1 00010000 0 0 0", rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_lt);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_drop: rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_sub;
    bit ok;
    issue(2, 1'b1, 32'd5, 32'd7);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_sum !== 32'hFFFFFFFE || rsp_cout !== 1'b0 || rsp_lt !== 1'b1 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL sub_5_7: ok=%b sum=%h cout=%b lt=%b id=%0d want fffffffe 0 1 2", ok, rsp_sum, rsp_cout, rsp_lt, rsp_id);
    end
    drain();
    issue(2, 1'b1, 32'd7, 32'd5);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_sum !== 32'd2 || rsp_cout !== 1'b1 || rsp_lt !== 1'b0) begin
      errors++; $display("FAIL sub_7_5: ok=%b sum=%h cout=%b lt=%b want 00000002 1 0", ok, rsp_sum, rsp_cout, rsp_lt);
    end
    drain();
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] order [5];
    int n = 0, cyc = 0, last = 0;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*OP_W +: OP_W] = OP_W'(i);
      req_b[i*OP_W +: OP_W] = 32'd1;
    end
    req_sub = '0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    while (n < 5 && cyc < 40) begin
      #1;
      if (|req_ready) begin
        checks++;
        if (req_ready !== order[n] || (n > 0 && cyc - last != 4)) begin
          errors++; $display("FAIL rr_grant%0d: grant=%b gap=%0d want %b gap 4", n, req_ready, cyc - last, order[n]);
        end
        last = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    checks++;
    if (n != 5) begin errors++; $display("FAIL rr_timeout: grants=%0d want 5", n); end
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_hold;
    bit ok;
    req_a[3*OP_W +: OP_W] = 32'd1; req_b[3*OP_W +: OP_W] = 32'd2; req_sub[3] = 1'b0;
    issue(1, 1'b0, 32'h12345678, 32'h11111111);
    req_valid = 4'b1000;
    wait_rsp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_timeout: rsp_valid=%b want 1", rsp_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h23456789 || rsp_id !== 2'd1 || rsp_cout !== 1'b0 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL hold%0d: valid=%b sum=%h id=%0d cout=%b rdy=%b want 1 23456789 1 0 0000", k, rsp_valid, rsp_sum, rsp_id, rsp_cout, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL hold_resume: valid=%b rdy=%b want 0 1000", rsp_valid, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_sum !== 32'd3 || rsp_id !== 2'd3) begin
      errors++; $display("FAIL hold_next: ok=%b sum=%h id=%0d want 00000003 3", ok, rsp_sum, rsp_id);
    end
    drain();
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    bit seen = 0;
    issue(2, 1'b1, 32'hAAAA5555, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || add_a !== '0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL midrst_abort: valid=%b add_a=%h rdy=%b want 0 0000 0000", rsp_valid, add_a, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_quiet: rsp_valid rose after abort, want stays 0"); end
    req_a[2*OP_W +: OP_W] = 32'h00010000; req_b[2*OP_W +: OP_W] = 32'h1; req_sub[2] = 1'b1;
    req_a[3*OP_W +: OP_W] = 32'h0;
    req_valid = 4'b1100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL midrst_ptr: grant=%b want 0100", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_sum !== 32'h0000FFFF || rsp_cout !== 1'b1 || rsp_lt !== 1'b0 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL midrst_next: ok=%b sum=%h cout=%b lt=%b id=%0d want 0000ffff 1 0 2", ok, rsp_sum, rsp_cout, rsp_lt, rsp_id);
    end
    drain();
  endtask

`ifdef CLA_SCHED_ZERO_FLAG_EN
  task automatic test_zero;
    bit ok;
    issue(1, 1'b1, 32'h12345678, 32'h12345678);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_zero !== 1'b1 || rsp_cout !== 1'b1 || rsp_lt !== 1'b0) begin
      errors++; $display("FAIL zero_eq: ok=%b zero=%b cout=%b lt=%b want 1 1 0", ok, rsp_zero, rsp_cout, rsp_lt);
    end
    drain();
    issue(1, 1'b1, 32'h00010000, 32'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_zero !== 1'b0 || rsp_sum !== 32'h00010000) begin
      errors++; $display("FAIL zero_ne: ok=%b zero=%b sum=%h want 0 00010000", ok, rsp_zero, rsp_sum);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_round_robin();
    test_hold();
    test_reset_mid_run();
`ifdef CLA_SCHED_ZERO_FLAG_EN
    test_zero();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
